// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the memory-access stage.
//   dataBus_t   - widest supported datapath word
//   ma_state_t  - transaction FSM state (also exported on the debug port)
//   SZ_*        - access size codes held in funct3[1:0]
//   F3_*        - load/store funct3 encodings
//   size_bytes  - number of bytes touched by an access of a given size code
package mem_access_unit_pkg;

  localparam int XLEN_MAX = 64;

  typedef logic [XLEN_MAX-1:0] dataBus_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_WAIT_RD = 2'd2,
    ST_DONE    = 2'd3
  } ma_state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

  function automatic int unsigned size_bytes(input logic [1:0] sz);
    return 32'd1 << sz;
  endfunction

endpackage

// File: rtl/mem_access_unit_lsu_align.sv
// lsu_align: purely combinational lane alignment for one data-memory access.
//   offset      - low address bits selecting the starting byte lane
//   funct3      - access size (bits 1:0) and zero-extend flag (bit 2)
//   store_data  - unshifted store operand
//   load_rdata  - raw word returned by memory
//   be          - byte enables for the access
//   wdata       - store operand moved onto its byte lanes
//   load_data   - load result moved to bit 0 and sign/zero extended
//   misaligned  - access not naturally aligned, or size illegal for XLEN
module lsu_align
  import mem_access_unit_pkg::*;
#(
  parameter  int XLEN  = 32,
  localparam int NB    = XLEN / 8,
  localparam int OFS_W = $clog2(NB)
) (
  input  logic [OFS_W-1:0] offset,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  store_data,
  input  logic [XLEN-1:0]  load_rdata,
  output logic [NB-1:0]    be,
  output logic [XLEN-1:0]  wdata,
  output logic [XLEN-1:0]  load_data,
  output logic             misaligned
);

  logic [1:0]      sz;
  logic            illegal;
  logic [OFS_W-1:0] align_mask;
  logic [NB-1:0]   size_mask;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] keep_mask;
  logic            sign;

  assign sz = funct3[1:0];

  always_comb begin
    // Doubleword and LWU have no meaning on a 32-bit datapath.
    illegal    = (XLEN == 32) && ((sz == SZ_D) || (funct3 == F3_LWU));
    align_mask = OFS_W'(size_bytes(sz) - 32'd1);
    misaligned = illegal || ((offset & align_mask) != '0);

    size_mask  = NB'((32'd1 << size_bytes(sz)) - 32'd1);
    be         = size_mask << offset;
    wdata      = store_data << {offset, 3'b000};

    shifted    = load_rdata >> {offset, 3'b000};
    case (sz)
      SZ_B:    begin keep_mask = XLEN'(8'hFF);          sign = shifted[7];      end
      SZ_H:    begin keep_mask = XLEN'(16'hFFFF);       sign = shifted[15];     end
      SZ_W:    begin keep_mask = XLEN'(32'hFFFF_FFFF);  sign = shifted[31];     end
      default: begin keep_mask = '1;                    sign = shifted[XLEN-1]; end
    endcase
    sign      = sign & ~funct3[2];
    load_data = (shifted & keep_mask) | ({XLEN{sign}} & ~keep_mask);
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-access pipeline stage between EX and WB.
//   i_clk / i_rst        - clock, asynchronous active-high reset
//   i_clk_en             - pipeline advance enable (gates only the MA->WB register)
//   i_ex_*               - instruction fields from EX
//   o_dmem_* / i_dmem_*  - request/grant/response data-memory port
//   o_ma_stall           - hold EX and earlier while an access is outstanding
//   o_ma_*               - MA->WB pipeline register
//   o_dbg_state          - current transaction FSM state
//
// Handshake: a request is accepted in any cycle where o_dmem_req and
// i_dmem_gnt are both high; address, be and wdata stay stable until then.
// For loads, i_dmem_rvalid qualifies i_dmem_rdata at least one cycle after
// the accepting cycle and is ignored unless a read is outstanding.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter  int XLEN  = 32,
  parameter  int REG_W = 5,
  localparam int NB    = XLEN / 8,
  localparam int OFS_W = $clog2(NB)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clk_en,
  input  logic             i_ex_valid,
  input  logic             i_ex_mem_to_reg,
  input  logic             i_ex_reg_wr,
  input  logic             i_ex_mem_rd,
  input  logic             i_ex_mem_wr,
  input  logic [1:0]       i_ex_rw_sel,
  input  logic [XLEN-1:0]  i_ex_pc_plus_4,
  input  logic [XLEN-1:0]  i_ex_alu_result,
  input  logic [XLEN-1:0]  i_ex_reg_read_data2,
  input  logic [REG_W-1:0] i_ex_reg_dest,
  input  logic [2:0]       i_ex_funct3,
  output logic             o_dmem_req,
  output logic             o_dmem_we,
  output logic [XLEN-1:0]  o_dmem_addr,
  output logic [NB-1:0]    o_dmem_be,
  output logic [XLEN-1:0]  o_dmem_wdata,
  input  logic             i_dmem_gnt,
  input  logic             i_dmem_rvalid,
  input  logic [XLEN-1:0]  i_dmem_rdata,
  output logic             o_ma_stall,
  output logic             o_ma_valid,
  output logic             o_ma_mem_to_reg,
  output logic             o_ma_reg_wr,
  output logic             o_ma_misaligned,
  output logic [1:0]       o_ma_rw_sel,
  output logic [XLEN-1:0]  o_ma_pc_plus_4,
  output logic [XLEN-1:0]  o_ma_read_data,
  output logic [XLEN-1:0]  o_ma_result,
  output logic [REG_W-1:0] o_ma_reg_dest,
  output ma_state_t        o_dbg_state
);

  ma_state_t       state, state_nxt;
  logic            acc, is_load, mis;
  logic            req, complete, cap_buf, stall;
  logic [XLEN-1:0] ld_ext, ld_buf, ld_sel;

  lsu_align #(.XLEN(XLEN)) u_align (
    .offset     (i_ex_alu_result[OFS_W-1:0]),
    .funct3     (i_ex_funct3),
    .store_data (i_ex_reg_read_data2),
    .load_rdata (i_dmem_rdata),
    .be         (o_dmem_be),
    .wdata      (o_dmem_wdata),
    .load_data  (ld_ext),
    .misaligned (mis)
  );

  assign acc         = i_ex_valid & (i_ex_mem_rd | i_ex_mem_wr);
  assign is_load     = i_ex_mem_rd;
  assign o_dmem_addr = {i_ex_alu_result[XLEN-1:OFS_W], {OFS_W{1'b0}}};

  // "complete" means the instruction in EX leaves MA at this edge. A granted
  // store with the pipeline frozen parks in DONE so it is not reissued.
  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    complete  = 1'b0;
    cap_buf   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!acc || mis) begin
          complete = 1'b1;
        end else begin
          req = 1'b1;
          if (!i_dmem_gnt)   state_nxt = ST_REQ;
          else if (is_load)  state_nxt = ST_WAIT_RD;
          else if (i_clk_en) complete  = 1'b1;
          else               state_nxt = ST_DONE;
        end
      end
      ST_REQ: begin
        req = 1'b1;
        if (i_dmem_gnt) begin
          if (is_load)       state_nxt = ST_WAIT_RD;
          else if (i_clk_en) begin complete = 1'b1; state_nxt = ST_IDLE; end
          else               state_nxt = ST_DONE;
        end
      end
      ST_WAIT_RD: begin
        if (i_dmem_rvalid) begin
          cap_buf = 1'b1;
          if (i_clk_en) begin complete = 1'b1; state_nxt = ST_IDLE; end
          else          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (i_clk_en) begin complete = 1'b1; state_nxt = ST_IDLE; end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign stall       = acc & ~complete;
  assign o_ma_stall  = stall & ~i_rst;
  assign o_dmem_req  = req & ~i_rst;
  assign o_dmem_we   = o_dmem_req & ~is_load;
  assign o_dbg_state = state;

  // Once parked in DONE the live bus may have moved on; use the buffer.
  assign ld_sel = (state == ST_DONE) ? ld_buf : ld_ext;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state           <= ST_IDLE;
      ld_buf          <= '0;
      o_ma_valid      <= 1'b0;
      o_ma_mem_to_reg <= 1'b0;
      o_ma_reg_wr     <= 1'b0;
      o_ma_misaligned <= 1'b0;
      o_ma_rw_sel     <= '0;
      o_ma_pc_plus_4  <= '0;
      o_ma_read_data  <= '0;
      o_ma_result     <= '0;
      o_ma_reg_dest   <= '0;
    end else begin
      state <= state_nxt;
      if (cap_buf) ld_buf <= ld_ext;
      if (i_clk_en) begin
        if (stall) begin
          o_ma_valid      <= 1'b0;
          o_ma_reg_wr     <= 1'b0;
          o_ma_misaligned <= 1'b0;
        end else begin
          o_ma_valid      <= i_ex_valid;
          o_ma_mem_to_reg <= i_ex_mem_to_reg;
          o_ma_reg_wr     <= i_ex_reg_wr & ~(acc & mis);
          o_ma_misaligned <= acc & mis;
          o_ma_rw_sel     <= i_ex_rw_sel;
          o_ma_pc_plus_4  <= i_ex_pc_plus_4;
          o_ma_read_data  <= (acc & is_load & ~mis) ? ld_sel : '0;
          o_ma_result     <= i_ex_alu_result;
          o_ma_reg_dest   <= i_ex_reg_dest;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  localparam int W = 1 + 1 + 5 + 32 + 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic clk_en;
  always #5 clk = ~clk;

  // ---------------- 32-bit DUT signals ----------------
  logic        ex_valid, ex_mem_to_reg, ex_reg_wr, ex_mem_rd, ex_mem_wr;
  logic [1:0]  ex_rw_sel;
  logic [31:0] ex_pc, ex_alu, ex_st;
  logic [4:0]  ex_dest;
  logic [2:0]  ex_f3;
  logic        dmem_req, dmem_we, gnt, rvalid;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  be;
  logic        ma_stall, ma_valid, ma_m2r, ma_reg_wr, ma_mis;
  logic [1:0]  ma_rw;
  logic [31:0] ma_pc, ma_rd, ma_res;
  logic [4:0]  ma_dest;
  ma_state_t   dbg;

  // ---------------- 64-bit DUT signals ----------------
  logic        ex_valid64, gnt64, rvalid64;
  dataBus_t    ex_pc64, ex_alu64, ex_st64, rdata64;
  logic        req64, we64, stall64, valid64, m2r64, reg_wr64, mis64;
  dataBus_t    addr64, wdata64, pc64, rd64, res64;
  logic [7:0]  be64;
  logic [1:0]  rw64;
  logic [4:0]  dest64;
  ma_state_t   dbg64;

  mem_access_unit #(.XLEN(32), .REG_W(5)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_clk_en(clk_en),
    .i_ex_valid(ex_valid), .i_ex_mem_to_reg(ex_mem_to_reg), .i_ex_reg_wr(ex_reg_wr),
    .i_ex_mem_rd(ex_mem_rd), .i_ex_mem_wr(ex_mem_wr), .i_ex_rw_sel(ex_rw_sel),
    .i_ex_pc_plus_4(ex_pc), .i_ex_alu_result(ex_alu), .i_ex_reg_read_data2(ex_st),
    .i_ex_reg_dest(ex_dest), .i_ex_funct3(ex_f3),
    .o_dmem_req(dmem_req), .o_dmem_we(dmem_we), .o_dmem_addr(addr), .o_dmem_be(be),
    .o_dmem_wdata(wdata), .i_dmem_gnt(gnt), .i_dmem_rvalid(rvalid), .i_dmem_rdata(rdata),
    .o_ma_stall(ma_stall), .o_ma_valid(ma_valid), .o_ma_mem_to_reg(ma_m2r),
    .o_ma_reg_wr(ma_reg_wr), .o_ma_misaligned(ma_mis), .o_ma_rw_sel(ma_rw),
    .o_ma_pc_plus_4(ma_pc), .o_ma_read_data(ma_rd), .o_ma_result(ma_res),
    .o_ma_reg_dest(ma_dest), .o_dbg_state(dbg)
  );

  mem_access_unit #(.XLEN(64), .REG_W(5)) u_dut64 (
    .i_clk(clk), .i_rst(rst), .i_clk_en(clk_en),
    .i_ex_valid(ex_valid64), .i_ex_mem_to_reg(ex_mem_to_reg), .i_ex_reg_wr(ex_reg_wr),
    .i_ex_mem_rd(ex_mem_rd), .i_ex_mem_wr(ex_mem_wr), .i_ex_rw_sel(ex_rw_sel),
    .i_ex_pc_plus_4(ex_pc64), .i_ex_alu_result(ex_alu64), .i_ex_reg_read_data2(ex_st64),
    .i_ex_reg_dest(ex_dest), .i_ex_funct3(ex_f3),
    .o_dmem_req(req64), .o_dmem_we(we64), .o_dmem_addr(addr64), .o_dmem_be(be64),
    .o_dmem_wdata(wdata64), .i_dmem_gnt(gnt64), .i_dmem_rvalid(rvalid64), .i_dmem_rdata(rdata64),
    .o_ma_stall(stall64), .o_ma_valid(valid64), .o_ma_mem_to_reg(m2r64),
    .o_ma_reg_wr(reg_wr64), .o_ma_misaligned(mis64), .o_ma_rw_sel(rw64),
    .o_ma_pc_plus_4(pc64), .o_ma_read_data(rd64), .o_ma_result(res64),
    .o_ma_reg_dest(dest64), .o_dbg_state(dbg64)
  );

  // ---------------- counters and checker ----------------
  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- stimulus table ----------------
  typedef struct {
    logic        rd, wr, reg_wr;
    logic [2:0]  f3;
    logic [31:0] addr, sdata, rdata;
    int          gnt_dly;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata, exp_rdata;
    logic        exp_mis;
    int          exp_stall;
  } vec_t;

  function automatic vec_t mk(input logic rd, input logic wr, input logic reg_wr,
                              input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] sd, input logic [31:0] rdv,
                              input int gd, input logic [3:0] ebe,
                              input logic [31:0] ewd, input logic [31:0] erd,
                              input logic emis, input int est);
    vec_t v;
    v.rd = rd; v.wr = wr; v.reg_wr = reg_wr; v.f3 = f3; v.addr = a;
    v.sdata = sd; v.rdata = rdv; v.gnt_dly = gd; v.exp_be = ebe;
    v.exp_wdata = ewd; v.exp_rdata = erd; v.exp_mis = emis; v.exp_stall = est;
    return v;
  endfunction

  // ---------------- scoreboard monitor ----------------
  initial begin : monitor
    logic         en_s;
    logic [W-1:0] e, a;
    forever begin
      @(posedge clk);
      en_s = clk_en;
      @(negedge clk);
      if (en_s && !rst && ma_valid) begin
        a = {ma_mis, ma_reg_wr, ma_dest, ma_rd, ma_res};
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL wb_unexpected: o_ma_valid=1 with result 0x%0h, required no writeback", a);
        end else begin
          e = exp_q.pop_front();
          check("wb_fields", a, e);
        end
      end
    end
  end

  // ---------------- driver: one instruction through MA ----------------
  // Memory model: grant after gnt_dly cycles of request, read data one
  // cycle after the accepting cycle.
  task automatic run_txn(input vec_t v);
    int          stalls, cyc, since;
    bit          granted, done, saw_req, exp_req;
    logic [31:0] a0, wd0;
    logic [3:0]  be0;
    logic        we0;
    logic [4:0]  dest;
    stalls = 0; cyc = 0; since = 0; granted = 0; done = 0; saw_req = 0;
    a0 = '0; wd0 = '0; be0 = '0; we0 = 1'b0;
    exp_req = (v.rd | v.wr) & ~v.exp_mis;
    dest = 5'($urandom_range(1, 31));
    ex_valid = 1'b1; ex_mem_rd = v.rd; ex_mem_wr = v.wr; ex_reg_wr = v.reg_wr;
    ex_f3 = v.f3; ex_alu = v.addr; ex_st = v.sdata; ex_dest = dest; ex_pc = $urandom;
    rdata = v.rdata; rvalid = 1'b0;
    gnt = exp_req && (v.gnt_dly == 0);
    exp_q.push_back({v.exp_mis, v.reg_wr & ~v.exp_mis, dest, v.exp_rdata, v.addr});
    while (!done && cyc < 40) begin
      @(negedge clk);
      if (cyc > 0) check("bubble", ma_valid, 1'b0);
      if (dmem_req) begin
        if (!saw_req) begin a0 = addr; be0 = be; wd0 = wdata; we0 = dmem_we; end
        else check("req_hold", {addr, be, wdata}, {a0, be0, wd0});
        saw_req = 1;
        if (gnt && !granted) granted = 1;
      end
      if (ma_stall) stalls++;
      else done = 1;
      @(posedge clk);
      #1;
      cyc++;
      if (granted) since++;
      gnt    = exp_req && !granted && (cyc >= v.gnt_dly);
      rvalid = granted && v.rd && (since == 1);
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL txn_timeout: still stalled after %0d cycles, required completion", cyc);
    end
    check("stall_cycles", stalls, v.exp_stall);
    check("req_seen", saw_req, exp_req);
    if (exp_req) begin
      check("addr", a0, {v.addr[31:2], 2'b00});
      check("be", be0, v.exp_be);
      check("wdata", wd0, v.exp_wdata);
      check("we", we0, v.wr);
    end
    ex_valid = 1'b0; ex_mem_rd = 1'b0; ex_mem_wr = 1'b0; gnt = 1'b0; rvalid = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    vec_t vecs[16];
    vecs[0]  = mk(0, 1, 0, F3_SW,  32'h100, 32'hDEADBEEF, 32'h0,        0, 4'hF, 32'hDEADBEEF, 32'h0,        0, 0);
    vecs[1]  = mk(1, 0, 1, F3_LB,  32'h103, 32'h0,        32'h80FFFFFF, 0, 4'h8, 32'h0,        32'hFFFFFF80, 0, 1);
    vecs[2]  = mk(1, 0, 1, F3_LBU, 32'h103, 32'h0,        32'h80FFFFFF, 0, 4'h8, 32'h0,        32'h00000080, 0, 1);
    vecs[3]  = mk(0, 1, 0, F3_SH,  32'h102, 32'h1234,     32'h0,        3, 4'hC, 32'h12340000, 32'h0,        0, 3);
    vecs[4]  = mk(1, 0, 1, F3_LW,  32'h101, 32'h0,        32'h0,        0, 4'h0, 32'h0,        32'h0,        1, 0);
    vecs[5]  = mk(1, 0, 1, F3_LH,  32'h102, 32'h0,        32'h80010000, 0, 4'hC, 32'h0,        32'hFFFF8001, 0, 1);
    vecs[6]  = mk(1, 0, 1, F3_LHU, 32'h100, 32'h0,        32'h1234ABCD, 0, 4'h3, 32'h0,        32'h0000ABCD, 0, 1);
    vecs[7]  = mk(1, 0, 1, F3_LW,  32'h104, 32'h0,        32'hCAFEF00D, 2, 4'hF, 32'h0,        32'hCAFEF00D, 0, 3);
    vecs[8]  = mk(0, 1, 0, F3_SB,  32'h101, 32'h112233A5, 32'h0,        0, 4'h2, 32'h2233A500, 32'h0,        0, 0);
    vecs[9]  = mk(0, 1, 0, F3_SH,  32'h101, 32'h5555,     32'h0,        0, 4'h0, 32'h0,        32'h0,        1, 0);
    vecs[10] = mk(1, 0, 1, F3_LD,  32'h100, 32'h0,        32'h0,        0, 4'h0, 32'h0,        32'h0,        1, 0);
    vecs[11] = mk(1, 0, 1, F3_LWU, 32'h100, 32'h0,        32'h0,        0, 4'h0, 32'h0,        32'h0,        1, 0);
    vecs[12] = mk(0, 1, 0, F3_SD,  32'h100, 32'h0,        32'h0,        0, 4'h0, 32'h0,        32'h0,        1, 0);
    vecs[13] = mk(0, 0, 1, F3_LW,  32'h55,  32'h0,        32'h0,        0, 4'h0, 32'h0,        32'h0,        0, 0);
    vecs[14] = mk(1, 0, 1, F3_LB,  32'h101, 32'h0,        32'h12347F56, 1, 4'h2, 32'h0,        32'h0000007F, 0, 2);
    vecs[15] = mk(1, 0, 1, F3_LBU, 32'h102, 32'h0,        32'h00C80000, 0, 4'h4, 32'h0,        32'h000000C8, 0, 1);

    // Reset with an access presented: request and stall must stay low.
    rst = 1'b1; clk_en = 1'b1;
    ex_valid = 1'b1; ex_mem_rd = 1'b1; ex_mem_wr = 1'b0; ex_reg_wr = 1'b1;
    ex_mem_to_reg = 1'b1; ex_rw_sel = 2'd1; ex_f3 = F3_LW; ex_alu = 32'h100;
    ex_st = '0; ex_pc = '0; ex_dest = 5'd1; gnt = 1'b1; rvalid = 1'b0; rdata = '0;
    ex_valid64 = 1'b0; ex_pc64 = '0; ex_alu64 = '0; ex_st64 = '0;
    gnt64 = 1'b0; rvalid64 = 1'b0; rdata64 = '0;
    #12;
    check("rst_req", dmem_req, 1'b0);
    check("rst_stall", ma_stall, 1'b0);
    check("rst_state", dbg, ST_IDLE);
    check("rst_wb", {ma_valid, ma_m2r, ma_reg_wr, ma_mis, ma_rw, ma_pc, ma_rd, ma_res, ma_dest}, '0);
    check("rst_wb64", {valid64, reg_wr64, mis64, rd64, res64}, '0);
    ex_valid = 1'b0; ex_mem_rd = 1'b0; gnt = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 16; i++) run_txn(vecs[i]);

    // Randomised non-memory instructions: never stall, pass result through.
    for (int i = 0; i < 6; i++)
      run_txn(mk(0, 0, 1, F3_LW, $urandom, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0, 0));

    // LH whose data arrives while the pipeline is frozen: parks in DONE.
    ex_valid = 1'b1; ex_mem_rd = 1'b1; ex_mem_wr = 1'b0; ex_reg_wr = 1'b1;
    ex_f3 = F3_LH; ex_alu = 32'h100; ex_dest = 5'd9; rdata = 32'h00008080; gnt = 1'b1;
    @(negedge clk);
    check("done_req", {dmem_req, ma_stall}, 2'b11);
    @(posedge clk); #1;
    gnt = 1'b0; clk_en = 1'b0; rvalid = 1'b1;
    @(negedge clk);
    check("done_wait_state", dbg, ST_WAIT_RD);
    @(posedge clk); #1;
    rvalid = 1'b0; rdata = 32'h0;
    @(negedge clk);
    check("done_state", dbg, ST_DONE);
    check("done_stall", ma_stall, 1'b1);
    check("done_held_wb", ma_valid, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check("done_state_hold", dbg, ST_DONE);
    @(posedge clk); #1;
    clk_en = 1'b1;
    exp_q.push_back({1'b0, 1'b1, 5'd9, 32'hFFFF8080, 32'h100});
    @(negedge clk);
    check("done_release", ma_stall, 1'b0);
    @(posedge clk); #1;
    ex_valid = 1'b0; ex_mem_rd = 1'b0;
    @(negedge clk);
    check("done_idle", dbg, ST_IDLE);
    @(posedge clk); #1;

    // Reset while a read is outstanding; the late rvalid must be ignored.
    ex_valid = 1'b1; ex_mem_rd = 1'b1; ex_f3 = F3_LW; ex_alu = 32'h200; gnt = 1'b1;
    @(posedge clk); #1;
    gnt = 1'b0;
    @(negedge clk);
    check("rst2_wait_state", dbg, ST_WAIT_RD);
    #1;
    rst = 1'b1;
    #1;
    check("rst2_state", dbg, ST_IDLE);
    check("rst2_req_stall", {dmem_req, ma_stall}, 2'b00);
    check("rst2_wb", {ma_valid, ma_reg_wr, ma_rd, ma_res}, '0);
    ex_valid = 1'b0; ex_mem_rd = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; rvalid = 1'b1; rdata = 32'h13579BDF;
    @(negedge clk);
    check("rst2_rvalid_ignored", dbg, ST_IDLE);
    @(posedge clk); #1;
    rvalid = 1'b0;
    @(negedge clk);
    check("rst2_no_wb", {ma_valid, ma_rd}, '0);
    @(posedge clk); #1;

    // 64-bit instance: LD at 0x8 returns the whole doubleword.
    ex_valid64 = 1'b1; ex_mem_rd = 1'b1; ex_mem_wr = 1'b0; ex_reg_wr = 1'b1;
    ex_f3 = F3_LD; ex_alu64 = 64'h8; rdata64 = 64'h0123456789ABCDEF; gnt64 = 1'b1;
    @(negedge clk);
    check("ld64_req", {req64, stall64}, 2'b11);
    check("ld64_be", be64, 8'hFF);
    check("ld64_addr", addr64, 64'h8);
    @(posedge clk); #1;
    gnt64 = 1'b0; rvalid64 = 1'b1;
    @(negedge clk);
    check("ld64_stall", stall64, 1'b0);
    @(posedge clk); #1;
    ex_valid64 = 1'b0; ex_mem_rd = 1'b0; rvalid64 = 1'b0;
    @(negedge clk);
    check("ld64_wb", {valid64, mis64, rd64}, {1'b1, 1'b0, 64'h0123456789ABCDEF});

    repeat (3) @(posedge clk);
    #1;
    check("queue_drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
